// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus responder with TX FIFO,
// STATUS and BAUD_DIV registers, and a registered serial output.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic        rd_strobe,
    input  logic [3:0]  wr_strobe,
    output logic [31:0] data_out,
    output logic        tx,
    output logic        irq
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- bus decode ----------------
    logic       hit;
    logic [1:0] off;
    logic       push, div_wr, status_rd;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign off       = addr[3:2];
    assign push      = hit && (off == 2'd0) && wr_strobe[0];
    assign div_wr    = hit && (off == 2'd2);
    assign status_rd = rd_strobe && hit && (off == 2'd1);

    // ---------------- FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, empty, pop, push_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A pop frees a slot in the same cycle, so push-while-full is fine then.
    assign push_ok = push && (!full || pop);

    // FIFO storage; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= data_in[7:0];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a fresh drop beats the read-to-clear
    logic overflow;
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (push && !push_ok)
            overflow <= 1'b1;
        else if (status_rd)
            overflow <= 1'b0;
    end

    // ---------------- baud divider register ----------------
    logic [15:0] baud_div, div_eff;
    assign div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;

    // BAUD_DIV byte-lane writes
    always_ff @(posedge clk) begin
        if (rst)
            baud_div <= DEFAULT_DIV;
        else if (div_wr) begin
            if (wr_strobe[0]) baud_div[7:0]  <= data_in[7:0];
            if (wr_strobe[1]) baud_div[15:8] <= data_in[15:8];
        end
    end

    // ---------------- serializer FSM ----------------
    state_t      state, state_n;
    logic [15:0] cnt, cnt_n, div_lat, div_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shift, shift_n;
    logic        bit_end;

    assign bit_end = (cnt == div_lat - 16'd1);

    // FSM and datapath state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div_lat <= 16'd1;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_lat <= div_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
        end
    end

    // Next-state logic; divider is frozen per frame in div_lat
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        div_n   = div_lat;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rptr];
                    div_n   = div_eff;
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else
                    cnt_n = cnt + 16'd1;
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                    else
                        bit_n = bit_idx + 3'd1;
                end else
                    cnt_n = cnt + 16'd1;
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else
                    cnt_n = cnt + 16'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered line and interrupt, one cycle behind the FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            tx  <= 1'b1;
            irq <= 1'b1;
        end else begin
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
                default: tx <= 1'b1;
            endcase
            irq <= empty && (state == IDLE);
        end
    end

    // ---------------- read path ----------------
    logic [31:0] cnt32, rd_val;
    assign cnt32 = 32'(count);

    // Register mux; TXDATA and the reserved slot read as zero
    always_comb begin
        rd_val = '0;
        case (off)
            2'd1:    rd_val = {20'd0, cnt32[3:0], 4'd0, overflow,
                               (state != IDLE), empty, full};
            2'd2:    rd_val = {16'd0, baud_div};
            default: rd_val = '0;
        endcase
    end

    // Read data holds between strobes and is zero on a miss
    always_ff @(posedge clk) begin
        if (rst)
            data_out <= '0;
        else if (rd_strobe)
            data_out <= hit ? rd_val : 32'd0;
    end

    logic unused_bits;
    assign unused_bits = ^{data_in[31:16], wr_strobe[3:2], addr[1:0]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing,
// FIFO overflow, divider handling and mid-frame reset.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_4000;

    logic        clk, rst;
    logic [31:0] addr, data_in, data_out;
    logic        rd_strobe;
    logic [3:0]  wr_strobe;
    logic        tx, irq;

    int n_vec = 0;
    int n_err = 0;

    mmio_uart_tx dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .rd_strobe(rd_strobe), .wr_strobe(wr_strobe),
        .data_out(data_out), .tx(tx), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start at a negedge and return at the next negedge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        addr = a; data_in = d; wr_strobe = s;
        @(negedge clk);
        wr_strobe = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
        d = data_out;
    endtask

    task automatic read_expect(input logic [31:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] d;
        bus_read(a, d);
        n_vec++;
        if (d !== exp) begin
            n_err++;
            $display("FAIL %s: data_out=%h expected %h", nm, d, exp);
        end
    endtask

    // k counts negedges after the push edge; tx sampled k>=2 is frame bit (k-2)/div
    task automatic check_frame(input logic [7:0] d, input int div, input int k0, input string nm);
        logic [9:0] fr;
        logic       e;
        fr = {1'b1, d, 1'b0};
        for (int k = k0 + 1; k <= 1 + 10 * div; k++) begin
            @(negedge clk);
            e = (k < 2) ? 1'b1 : fr[(k - 2) / div];
            n_vec++;
            if (tx !== e) begin
                n_err++;
                $display("FAIL %s k=%0d: tx=%b expected %b", nm, k, tx, e);
            end
        end
    endtask

    task automatic wait_idle(input int max, input string nm);
        int n = 0;
        while (irq !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL %s: irq=%b expected 1 within %0d cycles", nm, irq, max);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; addr = 0; data_in = 0; rd_strobe = 0; wr_strobe = 0;
        @(negedge clk);
        @(negedge clk);
        n_vec += 3;
        if (tx !== 1'b1)       begin n_err++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
        if (irq !== 1'b1)      begin n_err++; $display("FAIL reset_irq: irq=%b expected 1", irq); end
        if (data_out !== 32'd0) begin n_err++; $display("FAIL reset_dout: data_out=%h expected 0", data_out); end
        rst = 1'b0;
        read_expect(BASE + 32'h4, 32'h0000_0002, "reset_status");
        read_expect(BASE + 32'h8, 32'h0000_0004, "reset_baud");
    endtask

    task automatic test_frame();
        bus_write(BASE, 32'h0000_00A5, 4'b0001);
        check_frame(8'hA5, 4, 0, "frame_a5");
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL frame_irq_busy: irq=%b expected 0", irq); end
        @(negedge clk);
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL frame_irq_done: irq=%b expected 1", irq); end
    endtask

    task automatic test_overflow();
        // five consecutive pushes: first is popped at once, four fill the FIFO
        for (int i = 0; i < 5; i++) begin
            addr = BASE; data_in = 32'h10 + 32'(i); wr_strobe = 4'b0001;
            @(negedge clk);
        end
        wr_strobe = 4'd0;
        read_expect(BASE + 32'h4, 32'h0000_0405, "ovf_5_status");
        wait_idle(400, "ovf_5_drain");
        read_expect(BASE + 32'h4, 32'h0000_0002, "ovf_5_empty");
        for (int i = 0; i < 6; i++) begin
            addr = BASE; data_in = 32'h20 + 32'(i); wr_strobe = 4'b0001;
            @(negedge clk);
        end
        wr_strobe = 4'd0;
        read_expect(BASE + 32'h4, 32'h0000_040D, "ovf_6_status");
        read_expect(BASE + 32'h4, 32'h0000_0405, "ovf_6_cleared");
        wait_idle(400, "ovf_6_drain");
    endtask

    task automatic test_div_zero();
        bus_write(BASE + 32'h8, 32'h0000_0000, 4'b0011);
        read_expect(BASE + 32'h8, 32'h0000_0000, "div0_read");
        bus_write(BASE, 32'h0000_0000, 4'b0001);
        check_frame(8'h00, 1, 0, "div0_frame");
        wait_idle(10, "div0_idle");
    endtask

    task automatic test_div_change();
        bus_write(BASE + 32'h8, 32'h0000_0004, 4'b0011);
        bus_write(BASE, 32'h0000_003C, 4'b0001);
        bus_write(BASE, 32'h0000_0081, 4'b0001);
        bus_write(BASE + 32'h8, 32'h0000_0008, 4'b0011);
        check_frame(8'h3C, 4, 2, "divchg_first");
        check_frame(8'h81, 8, 0, "divchg_second");
        wait_idle(20, "divchg_idle");
    endtask

    task automatic test_miss_and_reset();
        logic ok;
        read_expect(BASE + 32'h4, 32'h0000_0002, "status_before_miss");
        @(negedge clk);
        n_vec++;
        if (data_out !== 32'h2) begin n_err++; $display("FAIL dout_hold: data_out=%h expected 2", data_out); end
        read_expect(32'h0000_5000, 32'h0, "miss_read");
        read_expect(BASE + 32'h4, 32'h0000_0002, "status_again");
        read_expect(BASE + 32'hC, 32'h0, "reserved_read");
        read_expect(BASE + 32'h8, 32'h0000_0008, "baud_read");
        bus_write(BASE + 32'h8, 32'h0000_0004, 4'b0011);
        bus_write(BASE, 32'h0000_0055, 4'b0001);
        bus_write(BASE, 32'h0000_0066, 4'b0001);
        for (int i = 0; i < 13; i++) @(negedge clk);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL mid_frame_busy: irq=%b expected 0", irq); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec += 2;
        if (tx !== 1'b1)  begin n_err++; $display("FAIL rst_mid_tx: tx=%b expected 1", tx); end
        if (irq !== 1'b1) begin n_err++; $display("FAIL rst_mid_irq: irq=%b expected 1", irq); end
        read_expect(BASE + 32'h4, 32'h0000_0002, "rst_mid_status");
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL rst_no_frames: tx=%b expected steady 1", tx); end
    endtask

    initial begin
        rst = 1'b1; addr = 0; data_in = 0; rd_strobe = 0; wr_strobe = 0;
        @(negedge clk);
        test_reset();
        test_frame();
        test_overflow();
        test_div_zero();
        test_div_change();
        test_miss_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
